// File: rtl/adder_tree_pipe.sv
// Fully pipelined balanced adder tree: sums NUM_INPUTS operands at full precision,
// one register per tree level, with a valid bit shifted alongside the data.
module adder_tree_pipe #(
    parameter int unsigned  NUM_INPUTS = 3,
    parameter int unsigned  DATA_W     = 8,
    parameter bit           SIGNED     = 1'b0,
    localparam int unsigned LEVELS     = (NUM_INPUTS >= 2) ? $clog2(NUM_INPUTS) : 1,
    localparam int unsigned SUM_W      = DATA_W + $clog2(NUM_INPUTS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  logic [NUM_INPUTS*DATA_W-1:0] i_data,
    output logic                         o_valid,
    output logic [SUM_W-1:0]             o_sum
);

    // Number of nodes remaining after lvl halving steps (level_count(0) = operand count).
    function automatic int unsigned level_count(int unsigned lvl);
        int unsigned n = NUM_INPUTS;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Index of the first register of tree level lvl inside the flat node vector.
    function automatic int unsigned node_base(int unsigned lvl);
        int unsigned b = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            b += level_count(i + 1);
        end
        return b;
    endfunction

    localparam int unsigned TotalNodes = node_base(LEVELS);

    logic [SUM_W-1:0]            ext [NUM_INPUTS];
    logic [TotalNodes*SUM_W-1:0] nodes_d;
    logic [TotalNodes*SUM_W-1:0] nodes_q;
    logic [LEVELS-1:0]           valid_q;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ext
        logic [DATA_W-1:0] op;
        assign op = i_data[k*DATA_W +: DATA_W];
        if (SIGNED) begin : g_sx
            assign ext[k] = SUM_W'($signed(op));
        end else begin : g_zx
            assign ext[k] = SUM_W'(op);
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned PrevCnt = level_count(l);
        localparam int unsigned Cnt     = level_count(l + 1);
        localparam int unsigned Base    = node_base(l);

        for (genvar j = 0; j < Cnt; j++) begin : g_node
            logic [SUM_W-1:0] a;
            logic [SUM_W-1:0] b;

            if (l == 0) begin : g_in
                assign a = ext[2*j];
                if (2*j + 1 < PrevCnt) begin : g_pair
                    assign b = ext[2*j+1];
                end else begin : g_odd
                    assign b = '0;
                end
            end else begin : g_prev
                localparam int unsigned PrevBase = node_base(l - 1);
                assign a = nodes_q[(PrevBase + 2*j)*SUM_W +: SUM_W];
                if (2*j + 1 < PrevCnt) begin : g_pair
                    assign b = nodes_q[(PrevBase + 2*j + 1)*SUM_W +: SUM_W];
                end else begin : g_odd
                    assign b = '0;
                end
            end

            // Unpaired operands add zero, giving a delay-only stage.
            assign nodes_d[(Base + j)*SUM_W +: SUM_W] = a + b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            nodes_q <= '0;
            valid_q <= '0;
        end else if (i_en) begin
            nodes_q <= nodes_d;
            valid_q <= LEVELS'({valid_q, i_valid});
        end
    end

    assign o_sum   = nodes_q[(TotalNodes-1)*SUM_W +: SUM_W];
    assign o_valid = valid_q[LEVELS-1];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe across several parameter sets.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;
    int   exp_val[$];
    int   exp_due[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u: default unsigned, s: signed, w: N8 W4, t: N5 W8, o: N1 W8
    logic        en_u, val_u, ov_u;
    logic [23:0] data_u;
    logic [9:0]  os_u;
    logic        en_s, val_s, ov_s;
    logic [23:0] data_s;
    logic [9:0]  os_s;
    logic        en_w, val_w, ov_w;
    logic [31:0] data_w;
    logic [6:0]  os_w;
    logic        en_t, val_t, ov_t;
    logic [39:0] data_t;
    logic [10:0] os_t;
    logic        en_o, val_o, ov_o;
    logic [7:0]  data_o;
    logic [7:0]  os_o;

    adder_tree_pipe u_dut_u (
        .i_clk(clk), .i_rst(rst), .i_en(en_u), .i_valid(val_u), .i_data(data_u),
        .o_valid(ov_u), .o_sum(os_u)
    );

    adder_tree_pipe #(.NUM_INPUTS(3), .DATA_W(8), .SIGNED(1'b1)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_en(en_s), .i_valid(val_s), .i_data(data_s),
        .o_valid(ov_s), .o_sum(os_s)
    );

    adder_tree_pipe #(.NUM_INPUTS(8), .DATA_W(4), .SIGNED(1'b0)) u_dut_w (
        .i_clk(clk), .i_rst(rst), .i_en(en_w), .i_valid(val_w), .i_data(data_w),
        .o_valid(ov_w), .o_sum(os_w)
    );

    adder_tree_pipe #(.NUM_INPUTS(5), .DATA_W(8), .SIGNED(1'b0)) u_dut_t (
        .i_clk(clk), .i_rst(rst), .i_en(en_t), .i_valid(val_t), .i_data(data_t),
        .o_valid(ov_t), .o_sum(os_t)
    );

    adder_tree_pipe #(.NUM_INPUTS(1), .DATA_W(8), .SIGNED(1'b0)) u_dut_o (
        .i_clk(clk), .i_rst(rst), .i_en(en_o), .i_valid(val_o), .i_data(data_o),
        .o_valid(ov_o), .o_sum(os_o)
    );

    task automatic test_reset();
        rst = 1'b1;
        en_u = 1'b1; val_u = 1'b0; data_u = '0;
        en_s = 1'b1; val_s = 1'b0; data_s = '0;
        en_w = 1'b1; val_w = 1'b0; data_w = '0;
        en_t = 1'b1; val_t = 1'b0; data_t = '0;
        en_o = 1'b1; val_o = 1'b0; data_o = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++; if (ov_u !== 1'b0) $display("FAIL reset_ov_u: got %b expected 0", ov_u); else npass++;
        nchk++; if (os_u !== '0) $display("FAIL reset_os_u: got %0d expected 0", os_u); else npass++;
        nchk++; if (ov_s !== 1'b0) $display("FAIL reset_ov_s: got %b expected 0", ov_s); else npass++;
        nchk++; if (os_s !== '0) $display("FAIL reset_os_s: got %0d expected 0", os_s); else npass++;
        nchk++; if (ov_w !== 1'b0) $display("FAIL reset_ov_w: got %b expected 0", ov_w); else npass++;
        nchk++; if (os_w !== '0) $display("FAIL reset_os_w: got %0d expected 0", os_w); else npass++;
        nchk++; if (ov_t !== 1'b0) $display("FAIL reset_ov_t: got %b expected 0", ov_t); else npass++;
        nchk++; if (os_t !== '0) $display("FAIL reset_os_t: got %0d expected 0", os_t); else npass++;
        nchk++; if (ov_o !== 1'b0) $display("FAIL reset_ov_o: got %b expected 0", ov_o); else npass++;
        nchk++; if (os_o !== '0) $display("FAIL reset_os_o: got %0d expected 0", os_o); else npass++;
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max();
        bit exp_ov;
        int ev;
        exp_val.delete(); exp_due.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ov = (exp_due.size() > 0) && (exp_due[0] == cyc);
            nchk++;
            if (ov_u !== exp_ov) $display("FAIL umax_valid: cycle %0d got %b expected %b", i, ov_u, exp_ov);
            else npass++;
            if (exp_ov) begin
                ev = exp_val.pop_front(); void'(exp_due.pop_front());
                nchk++;
                if (int'(os_u) !== ev) $display("FAIL umax_sum: got %0d expected %0d", os_u, ev);
                else npass++;
            end
            if (i == 0) begin
                data_u = {3{8'hFF}}; val_u = 1'b1;
                exp_val.push_back(765); exp_due.push_back(cyc + 2);
            end else begin
                data_u = '0; val_u = 1'b0;
            end
        end
    endtask

    task automatic test_signed();
        bit exp_ov;
        int ev;
        exp_val.delete(); exp_due.delete();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp_ov = (exp_due.size() > 0) && (exp_due[0] == cyc);
            nchk++;
            if (ov_s !== exp_ov) $display("FAIL signed_valid: cycle %0d got %b expected %b", i, ov_s, exp_ov);
            else npass++;
            if (exp_ov) begin
                ev = exp_val.pop_front(); void'(exp_due.pop_front());
                nchk++;
                if (int'($signed(os_s)) !== ev)
                    $display("FAIL signed_sum: got %0d expected %0d", $signed(os_s), ev);
                else npass++;
            end
            if (i == 0) begin
                data_s = {3{8'h80}}; val_s = 1'b1;
                exp_val.push_back(-384); exp_due.push_back(cyc + 2);
            end else if (i == 1) begin
                data_s = {8'h00, 8'hFF, 8'h7F}; val_s = 1'b1;
                exp_val.push_back(126); exp_due.push_back(cyc + 2);
            end else begin
                data_s = '0; val_s = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp_ov;
        int ev;
        exp_val.delete(); exp_due.delete();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_ov = (exp_due.size() > 0) && (exp_due[0] == cyc);
            nchk++;
            if (ov_w !== exp_ov) $display("FAIL b2b_valid: cycle %0d got %b expected %b", i, ov_w, exp_ov);
            else npass++;
            if (exp_ov) begin
                ev = exp_val.pop_front(); void'(exp_due.pop_front());
                nchk++;
                if (int'(os_w) !== ev) $display("FAIL b2b_sum: got %0d expected %0d", os_w, ev);
                else npass++;
            end
            if (i < 10) begin
                for (int m = 0; m < 8; m++) data_w[m*4 +: 4] = 4'(i);
                val_w = 1'b1;
                exp_val.push_back(8 * i); exp_due.push_back(cyc + 3);
            end else begin
                data_w = '0; val_w = 1'b0;
            end
        end
    endtask

    task automatic test_stall();
        bit exp_ov;
        int ev;
        exp_val.delete(); exp_due.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_ov = (exp_due.size() > 0) && (exp_due[0] == cyc);
            nchk++;
            if (ov_t !== exp_ov) $display("FAIL stall_valid: cycle %0d got %b expected %b", i, ov_t, exp_ov);
            else npass++;
            if (exp_ov) begin
                ev = exp_val.pop_front(); void'(exp_due.pop_front());
                nchk++;
                if (int'(os_t) !== ev) $display("FAIL stall_sum: got %0d expected %0d", os_t, ev);
                else npass++;
            end
            if (i >= 1 && i <= 5) begin
                nchk++;
                if (os_t !== '0) $display("FAIL stall_frozen_sum: cycle %0d got %0d expected 0", i, os_t);
                else npass++;
            end
            if (i == 0) begin
                data_t = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; val_t = 1'b1; en_t = 1'b1;
                exp_val.push_back(15); exp_due.push_back(cyc + 3 + 4);
            end else if (i <= 4) begin
                // Stalled cycles carry junk that must never be captured.
                data_t = {5{8'hEE}}; val_t = 1'b1; en_t = 1'b0;
            end else begin
                data_t = '0; val_t = 1'b0; en_t = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        bit exp_ov;
        int ev;
        exp_val.delete(); exp_due.delete();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            exp_ov = (exp_due.size() > 0) && (exp_due[0] == cyc);
            nchk++;
            if (ov_w !== exp_ov) $display("FAIL rstmid_valid: cycle %0d got %b expected %b", i, ov_w, exp_ov);
            else npass++;
            if (exp_ov) begin
                ev = exp_val.pop_front(); void'(exp_due.pop_front());
                nchk++;
                if (int'(os_w) !== ev) $display("FAIL rstmid_sum: got %0d expected %0d", os_w, ev);
                else npass++;
            end
            if (i == 3) begin
                nchk++;
                if (os_w !== '0) $display("FAIL rstmid_cleared_sum: got %0d expected 0", os_w);
                else npass++;
            end
            rst = 1'b0;
            if (i <= 2) begin
                for (int m = 0; m < 8; m++) data_w[m*4 +: 4] = 4'(i + 1);
                val_w = 1'b1;
                if (i == 2) rst = 1'b1;
            end else if (i == 5) begin
                for (int m = 0; m < 8; m++) data_w[m*4 +: 4] = 4'd7;
                val_w = 1'b1;
                exp_val.push_back(56); exp_due.push_back(cyc + 3);
            end else begin
                data_w = '0; val_w = 1'b0;
            end
        end
    endtask

    task automatic test_single_input();
        bit exp_ov;
        int ev;
        exp_val.delete(); exp_due.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_ov = (exp_due.size() > 0) && (exp_due[0] == cyc);
            nchk++;
            if (ov_o !== exp_ov) $display("FAIL single_valid: cycle %0d got %b expected %b", i, ov_o, exp_ov);
            else npass++;
            if (exp_ov) begin
                ev = exp_val.pop_front(); void'(exp_due.pop_front());
                nchk++;
                if (int'(os_o) !== ev) $display("FAIL single_sum: got %0d expected %0d", os_o, ev);
                else npass++;
            end
            if (i == 0) begin
                data_o = 8'hAB; val_o = 1'b1;
                exp_val.push_back(171); exp_due.push_back(cyc + 1);
            end else begin
                data_o = '0; val_o = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_stall();
        test_reset_mid_flight();
        test_single_input();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, fully pipelined, balanced adder tree. It sums NUM_INPUTS operands of DATA_W bits each, in signed or unsigned mode, at full precision. Each tree level is registered, and a valid bit travels alongside the data. A global pipeline enable stalls the whole pipeline. The block is the generalised successor of the fixed 3-input registered adder, and serves datapaths that need wide multi-operand sums at full clock rate.

## Interface
- NUM_INPUTS, default 3: operand count; legal range 1..64.
- DATA_W, default 8: width of each operand in bits; minimum 1.
- SIGNED, default 0: 0 treats operands as unsigned (zero-extend); 1 treats them as two's complement (sign-extend).
- LEVELS, derived: clog2(NUM_INPUTS) when NUM_INPUTS ≥ 2, otherwise 1. Pipeline latency in cycles.
- SUM_W, derived: DATA_W + clog2(NUM_INPUTS). Full-precision output width.

Ports:
- i_clk, input, 1: the single clock; all state updates on its rising edge.
- i_rst, input, 1: reset, synchronous and active-high.
- i_en, input, 1: pipeline advance; low freezes every register.
- i_valid, input, 1: qualifies i_data in this cycle.
- i_data, input, NUM_INPUTS*DATA_W: operands packed flat; operand k occupies bits [k*DATA_W +: DATA_W].
- o_valid, output, 1: o_sum holds a completed result.
- o_sum, output, SUM_W: sum of one input beat.

## Operation
- Operands are extended to SUM_W bits at the tree input, using zero- or sign-extension per SIGNED. All adders are SUM_W wide, so overflow is impossible for any input combination.
- Level 0 pairs operands (0,1), (2,3), and so on, and registers the pairwise sums.
- An unpaired last operand at any level is registered unchanged (a delay-only stage). This keeps every path exactly LEVELS registers deep.
- Each following level pairs the previous level's registers in the same way, until one register remains. That register drives o_sum.
- With NUM_INPUTS = 1, the single extended operand passes through one register.
- The valid pipeline is a LEVELS-deep shift register fed by i_valid. Its last stage drives o_valid.
- Data registers load on every enabled cycle, whether or not i_valid is high. o_sum is meaningful only while o_valid = 1; when o_valid = 0, o_sum is don't-care apart from reset.
- There is no backpressure and no handshake beyond i_en. The producer must hold i_en low when downstream cannot accept.

## Timing
- Latency: a beat accepted at edge t (i_en = 1) appears on o_sum/o_valid right after edge t + LEVELS − 1, i.e. it is visible for the cycle following the LEVELS-th enabled edge.
- Throughput: one beat per enabled cycle, with no bubbles required.
- Stall: with i_en = 0, all data and valid registers hold. o_sum and o_valid stay unchanged for as long as i_en stays low. Latency counts enabled edges only.
- Reset: when i_rst = 1 at an edge, every data register clears to 0 and every valid stage clears to 0, whatever i_en is (reset has priority).
  - After reset: o_valid = 0 and o_sum = 0.
  - Beats in flight at reset are discarded, and none reappear afterwards.
- A beat presented in the same cycle as i_rst = 1 is dropped.
- When reset is released, the first beat with i_valid = 1 and i_en = 1 emerges LEVELS enabled edges later.
- Outputs come directly from registers; there is no combinational path from input to output.

## Test plan
- Default parameters (N=3, W=8, unsigned; LEVELS=2, SUM_W=10). Drive operands 255, 255, 255 with valid = 1 for one cycle. Required: o_valid high exactly 2 cycles later, o_sum = 765, then o_valid back to 0.
- SIGNED=1, N=3, W=8. Drive −128, −128, −128 (0x80 ×3). Required: o_sum = −384 (10'h280). Then drive 127, −1, 0; required: o_sum = 126.
- N=8, W=4, unsigned (LEVELS=3, SUM_W=7). Stream 10 back-to-back beats where every operand equals the beat index k = 0..9. Required: o_valid continuous for 10 cycles starting 3 cycles after the first beat, with o_sum = 8k in order.
- Stall, N=5, W=8 (LEVELS=3). Send beat {1,2,3,4,5}, then hold i_en low for 4 cycles starting one cycle after it. Required: result 15 appears after 3 enabled edges; o_sum and o_valid are frozen during the stall; no duplicate result and no lost result.
- Reset mid-flight. Send 3 consecutive beats, then assert i_rst for 1 cycle while they are in the pipeline. Required: o_valid = 0 and o_sum = 0 on the cycle after reset, and none of those 3 results ever appears. A beat sent after reset arrives with normal latency.
- N=1, W=8. Drive 0xAB. Required: o_sum = 0xAB with o_valid high exactly 1 cycle later.
